// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared widths, default debounce length and FSM state encoding
//               for the keypad capture controller.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int CODE_W              = 4;
  localparam int ENTRY_W             = 32;
  localparam int DEF_DEBOUNCE_CYCLES = 100000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    CAPTURE  = 2'd2,
    RELEASE  = 2'd3
  } key_state_e;

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_capture_ctrl_if
// Description : Processor-side bus of the keypad capture controller: write
//               port, valid/ack handshake and status. The FIFO signals exist
//               only when KEY_FIFO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_capture_ctrl_if;
  import keypad_pkg::*;

  logic               proc_we;
  logic [ENTRY_W-1:0] proc_wdata;
  logic               proc_ack;
  logic [ENTRY_W-1:0] entry;
  logic               key_valid;
  logic [CODE_W-1:0]  key_last;
  logic [3:0]         digit_cnt;
  logic               overflow;
  logic               busy;
`ifdef KEY_FIFO_EN
  logic               fifo_pop;
  logic [CODE_W-1:0]  fifo_data;
  logic               fifo_empty;
  logic               fifo_full;
`endif

`ifdef KEY_FIFO_EN
  modport master (
    output proc_we, proc_wdata, proc_ack, fifo_pop,
    input  entry, key_valid, key_last, digit_cnt, overflow, busy,
    input  fifo_data, fifo_empty, fifo_full
  );
  modport slave (
    input  proc_we, proc_wdata, proc_ack, fifo_pop,
    output entry, key_valid, key_last, digit_cnt, overflow, busy,
    output fifo_data, fifo_empty, fifo_full
  );
`else
  modport master (
    output proc_we, proc_wdata, proc_ack,
    input  entry, key_valid, key_last, digit_cnt, overflow, busy
  );
  modport slave (
    input  proc_we, proc_wdata, proc_ack,
    output entry, key_valid, key_last, digit_cnt, overflow, busy
  );
`endif

endinterface : keypad_capture_ctrl_if
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Synchronises the encoder strobe and code, debounces the
//               press, raises a capture request until granted, then waits for
//               a debounced release before accepting another key.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] key_code,
  input  logic              key_da,
  input  logic              cap_grant,
  output logic              cap_req,
  output logic [CODE_W-1:0] cap_code,
  output logic              busy
);

  localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0]             r_da_sync;
  logic [SYNC_STAGES-1:0][CODE_W-1:0] r_code_sync;
  // Marks when the synchroniser chain and the edge history hold real samples,
  // so a key still held across reset is not mistaken for a fresh press.
  logic [SYNC_STAGES:0]               r_settle;
  logic                               r_da_prev;
  logic [c_CNT_W-1:0]                 r_cnt;
  logic [CODE_W-1:0]                  r_code;
  key_state_e                         r_state;
  key_state_e                         w_state_nxt;
  logic                               w_da;
  logic [CODE_W-1:0]                  w_code;
  logic                               w_rise;
  logic                               w_cnt_done;

  assign w_da       = r_da_sync[SYNC_STAGES-1];
  assign w_code     = r_code_sync[SYNC_STAGES-1];
  assign w_rise     = w_da & ~r_da_prev & r_settle[SYNC_STAGES];
  assign w_cnt_done = (r_cnt == c_CNT_LAST);
  assign cap_code   = r_code;

  // Synchronisers and rising-edge history for the asynchronous encoder pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_da_sync   <= '0;
      r_code_sync <= '0;
      r_settle    <= '0;
      r_da_prev   <= 1'b0;
    end else begin
      r_da_sync   <= {r_da_sync[SYNC_STAGES-2:0], key_da};
      r_code_sync <= {r_code_sync[SYNC_STAGES-2:0], key_code};
      r_settle    <= {r_settle[SYNC_STAGES-1:0], 1'b1};
      r_da_prev   <= w_da;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shared stable-high / stable-low counter and the code latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_code <= '0;
    end else begin
      case (r_state)
        DEBOUNCE: begin
          if (w_da && w_cnt_done) begin
            r_code <= w_code;
          end
          r_cnt <= w_cnt_done ? '0 : r_cnt + 1'b1;
        end
        RELEASE: begin
          r_cnt <= (w_da || w_cnt_done) ? '0 : r_cnt + 1'b1;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_rise) w_state_nxt = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!w_da)           w_state_nxt = IDLE;
        else if (w_cnt_done) w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (cap_grant) w_state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!w_da && w_cnt_done) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Moore outputs
  always_comb begin
    cap_req = (r_state == CAPTURE);
    busy    = (r_state != IDLE);
  end

endmodule : key_debounce
`default_nettype wire

// File: rtl/keypad_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keypad_capture_ctrl
// Description : Keypad entry controller. Arbitrates the nibble entry register
//               between debounced key shift-ins and processor writes, and
//               reports each captured key through a valid/ack handshake.
//               Optional macro KEY_FIFO_EN adds a 4-deep FIFO of key codes.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_capture_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2,
  parameter int DIGITS          = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CODE_W-1:0]          key_code,
  input  logic                       key_da,
  keypad_capture_ctrl_if.slave       bus
);

  localparam int         c_REG_W  = CODE_W * DIGITS;
  localparam logic [3:0] c_DIGITS = 4'(DIGITS);

  logic               w_cap_req;
  logic [CODE_W-1:0]  w_cap_code;
  logic               w_busy;
  logic               w_grant;
  logic               w_push_drop;
  logic [c_REG_W-1:0] r_entry;
  logic [3:0]         r_digit_cnt;
  logic               r_overflow;
  logic               r_key_valid;
  logic [CODE_W-1:0]  r_key_last;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_key_debounce (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .key_da    (key_da),
    .cap_grant (w_grant),
    .cap_req   (w_cap_req),
    .cap_code  (w_cap_code),
    .busy      (w_busy)
  );

  // Processor writes win; a colliding shift waits exactly one cycle.
  assign w_grant = w_cap_req & ~bus.proc_we;

  // Entry register: processor write or key shift-in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_entry <= '0;
    end else if (bus.proc_we) begin
      r_entry <= c_REG_W'(bus.proc_wdata);
    end else if (w_grant) begin
      r_entry <= {r_entry[c_REG_W-CODE_W-1:0], w_cap_code};
    end
  end

  // Digit count saturates; overflow is sticky until the next processor write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digit_cnt <= '0;
      r_overflow  <= 1'b0;
    end else if (bus.proc_we) begin
      r_digit_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_grant && (r_digit_cnt != c_DIGITS)) begin
        r_digit_cnt <= r_digit_cnt + 1'b1;
      end
      if ((w_grant && (r_digit_cnt == c_DIGITS)) || w_push_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Key report handshake; a new capture beats a same-cycle acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_valid <= 1'b0;
      r_key_last  <= '0;
    end else if (w_grant) begin
      r_key_valid <= 1'b1;
      r_key_last  <= w_cap_code;
    end else if (bus.proc_ack) begin
      r_key_valid <= 1'b0;
    end
  end

  generate
    if (c_REG_W < ENTRY_W) begin : g_entry_pad
      assign bus.entry = {{(ENTRY_W - c_REG_W){1'b0}}, r_entry};
    end else begin : g_entry_full
      assign bus.entry = r_entry[ENTRY_W-1:0];
    end
  endgenerate

  assign bus.key_valid = r_key_valid;
  assign bus.key_last  = r_key_last;
  assign bus.digit_cnt = r_digit_cnt;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = w_busy;

`ifdef KEY_FIFO_EN
  logic [CODE_W-1:0] r_fifo_mem [4];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_fifo_cnt;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_pop;
  logic              w_push;

  assign w_fifo_empty = (r_fifo_cnt == 3'd0);
  assign w_fifo_full  = (r_fifo_cnt == 3'd4);
  assign w_pop        = bus.fifo_pop & ~w_fifo_empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign w_push       = w_grant & (~w_fifo_full | w_pop);
  assign w_push_drop  = w_grant & w_fifo_full & ~w_pop;

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= w_cap_code;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  assign bus.fifo_data  = r_fifo_mem[r_rd_ptr];
  assign bus.fifo_empty = w_fifo_empty;
  assign bus.fifo_full  = w_fifo_full;
`else
  assign w_push_drop = 1'b0;
`endif

endmodule : keypad_capture_ctrl
`default_nettype wire

// File: tb/tb_keypad_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_capture_ctrl
// Description : Self-checking bench: vector table, hand-written timing
//               sequences and random key/write/ack traffic against an
//               abstract model of the entry register and handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_capture_ctrl;
  import keypad_pkg::*;

  localparam int DEB    = 4;
  localparam int SYNC   = 2;
  localparam int DIGITS = 8;

  localparam int OP_WRITE  = 0;
  localparam int OP_PRESS  = 1;
  localparam int OP_ACK    = 2;
  localparam int OP_GLITCH = 3;

  typedef struct {
    int          op;
    logic [31:0] arg;
    logic [31:0] e_entry;
    logic        e_valid;
    logic [3:0]  e_last;
    logic [3:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_da = 1'b0;

  keypad_capture_ctrl_if bus();

  keypad_capture_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC),
    .DIGITS          (DIGITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_code (key_code),
    .key_da   (key_da),
    .bus      (bus.slave)
  );

  always #50 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Abstract model: entry is a string of nibbles, newest on the right
  logic [31:0] m_entry;
  logic [3:0]  m_last;
  int          m_cnt;
  logic        m_ovf;
  logic        m_valid;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_entry = '0; m_last = '0; m_cnt = 0; m_ovf = 1'b0; m_valid = 1'b0;
  endfunction

  function automatic void m_press(input logic [3:0] c);
    if (m_cnt == DIGITS) m_ovf = 1'b1;
    else                 m_cnt = m_cnt + 1;
    m_entry = {m_entry[27:0], c};
    m_last  = c;
    m_valid = 1'b1;
  endfunction

  function automatic void m_write(input logic [31:0] v);
    m_entry = v; m_cnt = 0; m_ovf = 1'b0;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " entry"},     bus.entry,                m_entry);
    chk({tag, " key_valid"}, 32'(bus.key_valid),       32'(m_valid));
    chk({tag, " key_last"},  32'(bus.key_last),        32'(m_last));
    chk({tag, " digit_cnt"}, 32'(bus.digit_cnt),       32'(m_cnt));
    chk({tag, " overflow"},  32'(bus.overflow),        32'(m_ovf));
    chk({tag, " busy"},      32'(bus.busy),            32'd0);
  endtask

  task automatic wait_idle();
    int k;
    repeat (SYNC + 2) @(posedge clk);
    for (k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (!bus.busy) break;
    end
    if (k == 300) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: busy still 1 after 300 cycles, expected 0");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c, input int hold);
    @(posedge clk); #1;
    key_code = c; key_da = 1'b1;
    repeat (hold) @(posedge clk);
    #1; key_da = 1'b0;
    wait_idle();
    m_press(c);
  endtask

  task automatic glitch(input int len);
    @(posedge clk); #1;
    key_code = 4'hE; key_da = 1'b1;
    repeat (len) @(posedge clk);
    #1; key_da = 1'b0;
    wait_idle();
  endtask

  task automatic write(input logic [31:0] v);
    @(posedge clk); #1;
    bus.proc_we = 1'b1; bus.proc_wdata = v;
    @(posedge clk); #1;
    bus.proc_we = 1'b0;
    m_write(v);
  endtask

  task automatic ack();
    @(posedge clk); #1;
    bus.proc_ack = 1'b1;
    @(posedge clk); #1;
    bus.proc_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic do_op(input int op, input logic [31:0] arg, input int hold);
    case (op)
      OP_WRITE: write(arg);
      OP_PRESS: press(arg[3:0], hold);
      OP_ACK:   ack();
      default:  glitch(int'(arg));
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " entry"},     bus.entry,          32'd0);
    chk({tag, " key_valid"}, 32'(bus.key_valid), 32'd0);
    chk({tag, " key_last"},  32'(bus.key_last),  32'd0);
    chk({tag, " digit_cnt"}, 32'(bus.digit_cnt), 32'd0);
    chk({tag, " overflow"},  32'(bus.overflow),  32'd0);
    chk({tag, " busy"},      32'(bus.busy),      32'd0);
  endtask

  initial begin
    bus.proc_we = 1'b0; bus.proc_wdata = '0; bus.proc_ack = 1'b0;
    m_reset();

    // Vector table: {op, arg, entry, valid, last, cnt, ovf}
    vecs.push_back('{OP_PRESS,  32'h5,        32'h00000005, 1'b1, 4'h5, 4'd1, 1'b0});
    vecs.push_back('{OP_ACK,    32'h0,        32'h00000005, 1'b0, 4'h5, 4'd1, 1'b0});
    vecs.push_back('{OP_ACK,    32'h0,        32'h00000005, 1'b0, 4'h5, 4'd1, 1'b0});
    vecs.push_back('{OP_GLITCH, 32'h2,        32'h00000005, 1'b0, 4'h5, 4'd1, 1'b0});
    vecs.push_back('{OP_WRITE,  32'h0,        32'h00000000, 1'b0, 4'h5, 4'd0, 1'b0});
    vecs.push_back('{OP_PRESS,  32'h1,        32'h00000001, 1'b1, 4'h1, 4'd1, 1'b0});
    vecs.push_back('{OP_PRESS,  32'h2,        32'h00000012, 1'b1, 4'h2, 4'd2, 1'b0});
    vecs.push_back('{OP_PRESS,  32'h3,        32'h00000123, 1'b1, 4'h3, 4'd3, 1'b0});
    vecs.push_back('{OP_PRESS,  32'h4,        32'h00001234, 1'b1, 4'h4, 4'd4, 1'b0});
    vecs.push_back('{OP_PRESS,  32'h5,        32'h00012345, 1'b1, 4'h5, 4'd5, 1'b0});
    vecs.push_back('{OP_PRESS,  32'h6,        32'h00123456, 1'b1, 4'h6, 4'd6, 1'b0});
    vecs.push_back('{OP_PRESS,  32'h7,        32'h01234567, 1'b1, 4'h7, 4'd7, 1'b0});
    vecs.push_back('{OP_PRESS,  32'h8,        32'h12345678, 1'b1, 4'h8, 4'd8, 1'b0});
    vecs.push_back('{OP_PRESS,  32'h9,        32'h23456789, 1'b1, 4'h9, 4'd8, 1'b1});
    vecs.push_back('{OP_WRITE,  32'hCAFE0000, 32'hCAFE0000, 1'b1, 4'h9, 4'd0, 1'b0});
    vecs.push_back('{OP_PRESS,  32'hF,        32'hAFE0000F, 1'b1, 4'hF, 4'd1, 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_all_zero("reset_release");

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].op, vecs[i].arg, (i == 0) ? 20 : 10);
      chk($sformatf("vec%0d entry", i),     bus.entry,          vecs[i].e_entry);
      chk($sformatf("vec%0d key_valid", i), 32'(bus.key_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d key_last", i),  32'(bus.key_last),  32'(vecs[i].e_last));
      chk($sformatf("vec%0d digit_cnt", i), 32'(bus.digit_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d overflow", i),  32'(bus.overflow),  32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d busy", i),      32'(bus.busy),      32'd0);
    end

    // Write colliding with the capture grant: write lands first, key on top.
    // Capture grant edge is SYNC+DEB+2 edges after the strobe is driven.
    @(posedge clk); #1;
    key_code = 4'h3; key_da = 1'b1;
    repeat (SYNC + DEB + 1) @(posedge clk);
    #1; bus.proc_we = 1'b1; bus.proc_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.proc_we = 1'b0;
    chk("collide_n entry",     bus.entry,          32'hDEADBEEF);
    chk("collide_n digit_cnt", 32'(bus.digit_cnt), 32'd0);
    @(posedge clk); #1;
    chk("collide_n1 entry",     bus.entry,          32'hEADBEEF3);
    chk("collide_n1 digit_cnt", 32'(bus.digit_cnt), 32'd1);
    chk("collide_n1 key_last",  32'(bus.key_last),  32'h3);
    key_da = 1'b0;
    wait_idle();
    m_write(32'hDEADBEEF);
    m_press(4'h3);
    check_model("collide_end");

    // Acknowledge coinciding with a new shift: new event keeps key_valid high
    @(posedge clk); #1;
    key_code = 4'h7; key_da = 1'b1;
    repeat (SYNC + DEB + 1) @(posedge clk);
    #1; bus.proc_ack = 1'b1;
    @(posedge clk); #1;
    bus.proc_ack = 1'b0;
    chk("ack_vs_shift key_valid", 32'(bus.key_valid), 32'd1);
    chk("ack_vs_shift entry",     bus.entry,          32'hADBEEF37);
    key_da = 1'b0;
    wait_idle();
    m_press(4'h7);
    check_model("ack_vs_shift_end");
    ack();
    check_model("ack_clear");

    // Reset during debounce aborts; a held key is not a fresh press
    write(32'h00000012);
    @(posedge clk); #1;
    key_code = 4'hA; key_da = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_debounce busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_reset();
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_model("held_after_reset");
    key_da = 1'b0;
    repeat (10) @(posedge clk);
    press(4'hA, 12);
    check_model("fresh_press");

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6)      press(4'($urandom_range(0, 15)), int'($urandom_range(8, 20)));
      else if (r < 7) write($urandom);
      else if (r < 9) ack();
      else            glitch(int'($urandom_range(1, 2)));
      check_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_keypad_capture_ctrl
`default_nettype wire

// File: doc/keypad_capture_ctrl.md
Name: keypad_capture_ctrl

Overview:
Sequences keypad entry from a 74C922-style encoder (4-bit code plus data-available strobe) into a 32-bit, 8-nibble entry register. Arbitrates that register between keypad shift-ins and processor writes. Sits between the PMOD keypad pins and the processor/display path, running on the 10 MHz clock. Exposes a valid/acknowledge handshake so the processor consumes each completed key event exactly once.

Parameters:
DEBOUNCE_CYCLES, 100000, cycles key_da must stay stable high before capture (10 ms at 10 MHz); must be >= 2
SYNC_STAGES, 2, synchronizer flops on key_da and key_code; must be >= 2
DIGITS, 8, nibbles held in entry register (register width = 4*DIGITS)

Ports:
clk  in  1  system clock (10 MHz)
rst  in  1  asynchronous, active-low reset
key_code  in  4  encoder code (A..D), asynchronous to clk
key_da  in  1  encoder data-available (E), asynchronous, active-high
proc_we  in  1  processor write strobe, one cycle
proc_wdata  in  32  processor write data
proc_ack  in  1  processor acknowledges key_valid
entry  out  32  entry register; newest nibble in [3:0]
key_valid  out  1  new key captured, not yet acknowledged
key_last  out  4  code of most recent captured key
digit_cnt  out  4  nibbles entered since last clear/write, saturates at DIGITS
overflow  out  1  sticky; key entered while digit_cnt == DIGITS
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst low, async): entry=0, key_valid=0, key_last=0, digit_cnt=0, overflow=0, busy=0; FSM to IDLE; debounce counter and synchronizers cleared. Reset mid-debounce or mid-release aborts with no capture.
- key_da and key_code each pass through SYNC_STAGES flops; all logic uses the synchronized copies.
- FSM:
  - IDLE: on synced key_da rising edge, go to DEBOUNCE and clear the counter.
  - DEBOUNCE: counter increments while key_da is high. If key_da drops, return to IDLE with no capture. When the counter reaches DEBOUNCE_CYCLES-1, latch the synced code and go to CAPTURE.
  - CAPTURE: one cycle; issue a shift request to the arbiter. Go to RELEASE once granted. If not granted, stay and retry next cycle.
  - RELEASE: wait until key_da has been low for DEBOUNCE_CYCLES consecutive cycles, then go to IDLE. A high level restarts the low count. Holding a key never repeats.
- Arbiter, one register update per cycle:
  - proc_we has priority. entry<=proc_wdata, digit_cnt<=0, overflow<=0; key_valid unchanged.
  - Shift grant, when proc_we is low: entry<={entry[27:0],code}; key_last<=code; key_valid<=1.
  - digit_cnt increments and saturates at DIGITS. If digit_cnt was already DIGITS, set overflow=1; the shift still occurs and the oldest nibble is lost.
  - Simultaneous proc_we and shift request: the write wins and the shift is granted next cycle, so the captured key lands on top of the written value. Maximum stall is 1 cycle per write.
- Handshake: key_valid stays high until a cycle with proc_ack=1, then clears next cycle.
  - If a new shift and proc_ack coincide, key_valid stays 1, because the new event wins.
  - proc_ack with key_valid=0 is ignored.
- busy=1 in DEBOUNCE, CAPTURE, RELEASE.
- Latency: key_da edge to entry/key_valid update = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles, with no write contention.

Optional Feature:
KEY_FIFO_EN
- Defined: adds a 4-deep FIFO of captured codes and ports fifo_pop (in 1), fifo_data (out 4, first-word-fall-through), fifo_empty (out 1), fifo_full (out 1).
  - Each granted shift also pushes the code.
  - Push when full drops the code and sets overflow.
  - Pop when empty is ignored.
  - Push and pop in the same cycle when full are both honoured.
  - Reset empties the FIFO.
- Undefined: no FIFO logic and no FIFO ports; only key_last/key_valid report keys.

Decomposition:
- Shared package keypad_pkg: FSM state enum (IDLE, DEBOUNCE, CAPTURE, RELEASE), CODE_W=4, ENTRY_W=32, default DEBOUNCE_CYCLES.
- One sub-module, key_debounce: synchronizer, counter, FSM, capture request/grant. The top holds the arbiter, entry register, handshake and optional FIFO.

Test Plan:
- DEBOUNCE_CYCLES=4. Press code 0x5, hold 20 cycles, release -> entry=0x00000005, key_valid=1, key_last=5, digit_cnt=1, exactly one capture.
- key_da glitch high for 2 cycles -> no capture, FSM back to IDLE, entry unchanged.
- Enter keys 1..9 in order -> entry=0x23456789, digit_cnt=8, overflow=1.
- proc_we=1, proc_wdata=0xDEADBEEF in the same cycle as the CAPTURE grant for key 0x3 -> cycle n: entry=0xDEADBEEF; cycle n+1: entry=0xEADBEEF3, digit_cnt=1.
- key_valid=1, assert proc_ack -> key_valid=0 next cycle. proc_ack coinciding with a new shift -> key_valid stays 1.
- Assert rst low during DEBOUNCE with entry=0x12 -> all outputs 0 immediately; release rst, key_da still high -> no capture until a fresh rising edge.
